// File: rtl/space_wire_pkg.sv
// Shared constants and FSM encoding for the SpaceWire receive character decoder.
// Control codes are listed as the 2-bit value assembled LSB-first from the wire.
package space_wire_pkg;

    localparam logic [1:0] CTRL_FCT = 2'b00;
    localparam logic [1:0] CTRL_EOP = 2'b01;
    localparam logic [1:0] CTRL_EEP = 2'b10;
    localparam logic [1:0] CTRL_ESC = 2'b11;

    // ESC+FCT as seen on the wire after the ESC parity bit, oldest bit in the MSB
    localparam logic [6:0] NULL_PATTERN = 7'b1110100;

    localparam int unsigned DATA_CHAR_LEN = 10;
    localparam int unsigned CTRL_CHAR_LEN = 4;

    typedef enum logic [2:0] {
        S_DISABLED  = 3'd0,
        S_WAIT_NULL = 3'd1,
        S_RUN       = 3'd2,
        S_ESC       = 3'd3,
        S_ERROR     = 3'd4
    } rx_state_t;

endpackage

// File: rtl/space_wire_rx_char_assembler.sv
// Collects P, flag and payload bits into one character; char_done is combinational
// and fires in the cycle the final bit is valid, with payload already including that bit.
module space_wire_rx_char_assembler
    import space_wire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       rx_bit,
    output logic       char_done,
    output logic       flag,
    output logic [7:0] payload,
    output logic       parity_ok
);

    logic [3:0] bit_cnt;
    logic       p_bit;
    logic       flag_bit;
    logic [7:0] data;
    logic       acc;
    logic [2:0] data_idx;
    logic [3:0] last_idx;

    assign data_idx  = 3'(bit_cnt - 4'd2);
    assign last_idx  = flag_bit ? 4'(CTRL_CHAR_LEN - 1) : 4'(DATA_CHAR_LEN - 1);
    assign char_done = bit_en && (bit_cnt >= 4'd2) && (bit_cnt == last_idx);
    assign flag      = flag_bit;
    // Odd parity spans the previous character's data bits plus this P and flag
    assign parity_ok = acc ^ p_bit ^ flag_bit;

    always_comb begin
        payload = data;
        if (bit_en && bit_cnt >= 4'd2) begin
            payload[data_idx] = rx_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            p_bit    <= 1'b0;
            flag_bit <= 1'b0;
            data     <= '0;
            acc      <= 1'b0;
        end else if (clear) begin
            bit_cnt  <= '0;
            p_bit    <= 1'b0;
            flag_bit <= 1'b0;
            data     <= '0;
            acc      <= 1'b0;
        end else if (bit_en) begin
            if (char_done) begin
                bit_cnt <= '0;
                acc     <= ^payload;
                data    <= '0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                case (bit_cnt)
                    4'd0:    p_bit    <= rx_bit;
                    4'd1:    flag_bit <= rx_bit;
                    default: data     <= payload;
                endcase
            end
        end
    end

endmodule

// File: rtl/space_wire_rx_char_decoder.sv
// Receive character decoder: NULL alignment, parity check and character classification.
// All events are registered one cycle after the final bit of a character is sampled.
module space_wire_rx_char_decoder
    import space_wire_pkg::*;
#(
    parameter logic FIRST_NULL_GATE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx_enable,
    input  logic       i_rx_bit,
    input  logic       i_rx_bit_valid,
    output logic       o_got_null,
    output logic       o_got_fct,
    output logic       o_got_time_code,
    output logic [7:0] o_rx_time_code,
    output logic       o_rx_data_valid,
    output logic [8:0] o_rx_data,
    output logic       o_parity_error,
    output logic       o_escape_error
);

    rx_state_t  state;
    logic [6:0] null_win;
    logic [6:0] null_win_next;
    logic       active;
    logic       asm_clear;
    logic       asm_bit_en;
    logic       char_done;
    logic       char_flag;
    logic       parity_ok;
    logic [7:0] payload;

    assign active        = (state == S_RUN) || (state == S_ESC);
    // Assembler is held clear outside character decoding so each run starts aligned
    assign asm_clear     = !i_rx_enable || !active;
    assign asm_bit_en    = i_rx_enable && active && i_rx_bit_valid;
    assign null_win_next = {null_win[5:0], i_rx_bit};

    space_wire_rx_char_assembler u_assembler (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clear     (asm_clear),
        .bit_en    (asm_bit_en),
        .rx_bit    (i_rx_bit),
        .char_done (char_done),
        .flag      (char_flag),
        .payload   (payload),
        .parity_ok (parity_ok)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= S_DISABLED;
            null_win        <= '0;
            o_got_null      <= 1'b0;
            o_got_fct       <= 1'b0;
            o_got_time_code <= 1'b0;
            o_rx_time_code  <= 8'h00;
            o_rx_data_valid <= 1'b0;
            o_rx_data       <= 9'h000;
            o_parity_error  <= 1'b0;
            o_escape_error  <= 1'b0;
        end else begin
            o_got_null      <= 1'b0;
            o_got_fct       <= 1'b0;
            o_got_time_code <= 1'b0;
            o_rx_data_valid <= 1'b0;
            o_parity_error  <= 1'b0;
            o_escape_error  <= 1'b0;
            if (state != S_WAIT_NULL) begin
                null_win <= '0;
            end

            if (!i_rx_enable) begin
                state <= S_DISABLED;
            end else begin
                case (state)
                    S_DISABLED: state <= FIRST_NULL_GATE ? S_WAIT_NULL : S_RUN;
                    S_WAIT_NULL: begin
                        if (i_rx_bit_valid) begin
                            null_win <= null_win_next;
                            if (null_win_next == NULL_PATTERN) begin
                                o_got_null <= 1'b1;
                                state      <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (char_done) begin
                            if (!parity_ok) begin
                                o_parity_error <= 1'b1;
                                state          <= S_ERROR;
                            end else if (char_flag) begin
                                case (payload[1:0])
                                    CTRL_FCT: o_got_fct <= 1'b1;
                                    CTRL_EOP: begin
                                        o_rx_data_valid <= 1'b1;
                                        o_rx_data       <= 9'h100;
                                    end
                                    CTRL_EEP: begin
                                        o_rx_data_valid <= 1'b1;
                                        o_rx_data       <= 9'h101;
                                    end
                                    default:  state <= S_ESC;
                                endcase
                            end else begin
                                o_rx_data_valid <= 1'b1;
                                o_rx_data       <= {1'b0, payload};
                            end
                        end
                    end
                    S_ESC: begin
                        if (char_done) begin
                            if (!parity_ok) begin
                                o_parity_error <= 1'b1;
                                state          <= S_ERROR;
                            end else if (char_flag) begin
                                if (payload[1:0] == CTRL_FCT) begin
                                    o_got_null <= 1'b1;
                                    state      <= S_RUN;
                                end else begin
                                    o_escape_error <= 1'b1;
                                    state          <= S_ERROR;
                                end
                            end else begin
                                o_got_time_code <= 1'b1;
                                o_rx_time_code  <= payload;
                                state           <= S_RUN;
                            end
                        end
                    end
                    S_ERROR: state <= S_ERROR;
                    default: state <= S_DISABLED;
                endcase
            end
        end
    end

endmodule
